// File: rtl/cpu_mc_ctrl.sv
// Multi-cycle control unit for the course CPU: sequences IF/ID/EX/MEM/WB and drives datapath
// enables/mux selects, with free-run/single-step control and a retired-instruction counter.
module cpu_mc_ctrl #(
    parameter int          CNT_W   = 16,
    parameter logic [5:0]  HALT_OP = 6'h3F
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Run,
    input  logic             Step,
    input  logic [5:0]       OP,
    input  logic [5:0]       Funct,
    input  logic             ALU_Z,
    input  logic             ALU_OF,
    output logic             PC_Write,
    output logic [1:0]       PC_Src,
    output logic             IR_Write,
    output logic             Reg_Write,
    output logic             RegDst,
    output logic             ALUSrc,
    output logic             MemToReg,
    output logic             Mem_Write,
    output logic [2:0]       ALU_OP,
    output logic [2:0]       State,
    output logic             Halt,
    output logic             Err,
    output logic [CNT_W-1:0] Instr_Cnt
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_IF   = 3'd1,
        S_ID   = 3'd2,
        S_EX   = 3'd3,
        S_MEM  = 3'd4,
        S_WB   = 3'd5,
        S_HALT = 3'd6,
        S_BAD  = 3'd7
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic              step_q, step_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              is_r, is_lw, is_sw, is_addi, is_beq, is_j, is_halt;
    logic              r_legal, legal, ovf_sens, step_edge, retire, set_err;
    logic [2:0]        r_alu;
    state_t            end_state;

    // Instruction decode from the IR fields; stable for the whole instruction after IF.
    always_comb begin
        is_r    = (OP == OP_RTYPE);
        is_lw   = (OP == OP_LW);
        is_sw   = (OP == OP_SW);
        is_addi = (OP == OP_ADDI);
        is_beq  = (OP == OP_BEQ);
        is_j    = (OP == OP_J);
        is_halt = (OP == HALT_OP);
        r_legal = 1'b1;
        r_alu   = 3'b000;
        case (Funct)
            FN_ADD:  r_alu = 3'b000;
            FN_SUB:  r_alu = 3'b001;
            FN_AND:  r_alu = 3'b010;
            FN_OR:   r_alu = 3'b011;
            FN_SLT:  r_alu = 3'b100;
            default: r_legal = 1'b0;
        endcase
        legal    = (is_r && r_legal) || is_lw || is_sw || is_addi || is_beq;
        ovf_sens = (is_r && (Funct == FN_ADD || Funct == FN_SUB)) || is_addi;
    end

    assign step_edge = Step & ~step_q;
    assign end_state = Run ? S_IF : S_IDLE;

    always_comb begin
        state_d   = state_q;
        retire    = 1'b0;
        set_err   = 1'b0;
        PC_Write  = 1'b0;
        PC_Src    = 2'b00;
        IR_Write  = 1'b0;
        Reg_Write = 1'b0;
        RegDst    = 1'b0;
        ALUSrc    = 1'b0;
        MemToReg  = 1'b0;
        Mem_Write = 1'b0;
        ALU_OP    = 3'b000;
        Halt      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Run || step_edge) state_d = S_IF;
            end
            S_IF: begin
                IR_Write = 1'b1;
                PC_Write = 1'b1;
                state_d  = S_ID;
            end
            S_ID: begin
                if (is_halt) begin
                    retire  = 1'b1;
                    state_d = S_HALT;
                end else if (is_j) begin
                    PC_Write = 1'b1;
                    PC_Src   = 2'b10;
                    retire   = 1'b1;
                    state_d  = end_state;
                end else if (legal) begin
                    state_d = S_EX;
                end else begin
                    set_err = 1'b1;
                    state_d = S_HALT;
                end
            end
            S_EX: begin
                ALUSrc = is_lw || is_sw || is_addi;
                ALU_OP = is_r ? r_alu : (is_beq ? 3'b001 : 3'b000);
                if (is_beq) begin
                    PC_Write = ALU_Z;
                    PC_Src   = 2'b01;
                    retire   = 1'b1;
                    state_d  = end_state;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else if (ALU_OF && ovf_sens) begin
                    // Overflowing arithmetic retires without writing the register file.
                    set_err = 1'b1;
                    retire  = 1'b1;
                    state_d = end_state;
                end else if (is_r || is_addi) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MEM: begin
                if (is_sw) begin
                    Mem_Write = 1'b1;
                    retire    = 1'b1;
                    state_d   = end_state;
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                Reg_Write = 1'b1;
                RegDst    = is_r;
                MemToReg  = is_lw;
                retire    = 1'b1;
                state_d   = end_state;
            end
            S_HALT: begin
                Halt    = 1'b1;
                state_d = S_HALT;
            end
            default: state_d = S_IDLE;
        endcase
        // Step edges outside IDLE are dropped because the edge register always tracks Step.
        step_d = Step;
        err_d  = err_q | set_err;
        cnt_d  = retire ? cnt_q + CNT_ONE : cnt_q;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= S_IDLE;
            step_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign State     = state_q;
    assign Err       = err_q;
    assign Instr_Cnt = cnt_q;

endmodule

// File: doc/cpu_mc_ctrl.md
Name: cpu_mc_ctrl

Overview:
Multi-cycle control unit for the course CPU datapath (PC, IR, register file, ALU, data memory). It sequences each instruction through IF/ID/EX/MEM/WB and drives the datapath write enables and mux selects. It supports free-run and single-step execution from a board switch and button, and keeps a retired-instruction counter for the 7-segment display path.

Parameters:
CNT_W, 16, width of the retired-instruction counter
HALT_OP, 6'h3F, opcode that stops the machine

Ports:
Clk  in  1  system clock, rising edge
Rst_n  in  1  asynchronous active-low reset
Run  in  1  level; 1 = free-run, 0 = single-step
Step  in  1  synchronous step button; internal rising-edge detect
OP  in  6  IR[31:26]
Funct  in  6  IR[5:0]
ALU_Z  in  1  ALU zero flag, valid in EX
ALU_OF  in  1  ALU signed overflow, valid in EX
PC_Write  out  1  load PC
PC_Src  out  2  00 = PC+4, 01 = branch target, 10 = jump target
IR_Write  out  1  load IR
Reg_Write  out  1  register-file write
RegDst  out  1  1 = rd, 0 = rt
ALUSrc  out  1  1 = sign-extended immediate, 0 = rt
MemToReg  out  1  1 = memory data, 0 = ALU result
Mem_Write  out  1  data-memory write
ALU_OP  out  3  000 add, 001 sub, 010 and, 011 or, 100 slt
State  out  3  current state encoding, for display
Halt  out  1  machine stopped
Err  out  1  sticky: illegal instruction or overflow seen
Instr_Cnt  out  CNT_W  retired-instruction count

Behaviour:
- Reset (async, Rst_n=0): State=IDLE, Instr_Cnt=0, Err=0, Halt=0, step-edge register=0; all enables 0, PC_Src=00, ALU_OP=000, mux selects 0. Release is clocked.
- State encoding: IDLE=0, IF=1, ID=2, EX=3, MEM=4, WB=5, HALT=6. State 7 is unreachable; if entered, next state is IDLE.
- IDLE: go to IF when Run=1 or a Step rising edge is detected. Otherwise hold.
- IF: IR_Write=1, PC_Write=1, PC_Src=00. Next state is ID.
- ID, by OP:
  - 000000 (R-type) -> EX
  - 100011 lw, 101011 sw, 001000 addi, 000100 beq -> EX
  - 000010 j: PC_Write=1, PC_Src=10; retire; next state is end-of-instruction
  - HALT_OP -> HALT and retire
  - any other opcode -> Err=1, HALT, no retire
- R-type Funct 0x20/0x22/0x24/0x25/0x2A maps to ALU_OP 000/001/010/011/100. Any other Funct is illegal and is handled as an illegal opcode at ID.
- EX:
  - ALUSrc=1 for lw, sw, addi; 0 otherwise.
  - ALU_OP=000 for lw/sw/addi; 001 for beq.
  - beq: PC_Write=ALU_Z, PC_Src=01; retire; end-of-instruction.
  - lw, sw -> MEM.
  - R-type, addi -> WB, except when ALU_OF=1 on add, sub or addi. In that case skip WB, set Err=1, retire, end-of-instruction.
- MEM:
  - sw: Mem_Write=1; retire; end-of-instruction.
  - lw -> WB.
- WB: Reg_Write=1. RegDst=1 for R-type, 0 otherwise. MemToReg=1 for lw. Retire; end-of-instruction.
- End-of-instruction: next state is IF if Run=1, else IDLE.
- Step edges seen while not in IDLE are discarded, not queued.
- Instruction latency in cycles: j=2, beq=3, sw=4, R/addi=4, lw=5.
- Retire: Instr_Cnt increments by 1 on the final cycle and wraps from all-ones to 0.
- HALT: Halt=1 and all enables are 0. Held until reset; Run and Step are ignored.
- Control outputs are a combinational decode of the registered State and OP/Funct. They are valid for the whole state cycle.
- Err is only cleared by reset.

Test Plan:
- Reset mid-EX of an add with Rst_n=0 asynchronously -> same cycle State=0, Reg_Write=0, Instr_Cnt=0; no WB occurs.
- Run=1 with add (OP=0, Funct=0x20) -> states 1,2,3,5,1; Reg_Write=1, RegDst=1 only in WB; Instr_Cnt=1 after 4 cycles.
- Run=1 with lw then sw -> lw takes 5 cycles with MemToReg=1 in WB; sw takes 4 cycles with Mem_Write=1 in MEM only; Instr_Cnt=2.
- beq with ALU_Z=1, then ALU_Z=0 -> PC_Write=1 with PC_Src=01 in EX for the first only; each takes 3 cycles; j takes 2 cycles with PC_Src=10.
- Run=0 with Step held high for 10 cycles -> exactly one instruction executes, then State=IDLE; a second edge runs the next instruction.
- addi with ALU_OF=1 -> no Reg_Write, Err=1, Instr_Cnt incremented. Then OP=6'h3F -> Halt=1, State=6, and Step is ignored. Illegal OP=6'h11 -> Err=1, Halt=1, Instr_Cnt unchanged.
- Instr_Cnt preloaded near wrap (CNT_W=4, run 17 instructions) -> Instr_Cnt=1.
